// File: rtl/stopwatch_ctrl.sv
// Purpose : stopwatch control FSM; counts timer base ticks into BCD mm:ss.cc and drives the timer and display.
// Latency : a tick updates the counter on the sampling edge (+2 cycles with BASETICK_SYNC); o_disp follows one cycle later.
// Backpressure: none; command pulses are acted on in the cycle they are sampled, or dropped when not legal in the current state.
//
// Ports:
//   i_sclk, i_reset (async, active-high)
//   i_start_stop, i_lap, i_clear : single-cycle command pulses (priority clear > start_stop > lap)
//   i_basetick                   : 100 Hz square wave from the timer
//   o_timerenb, o_timer_clr_n    : timer enable / one-cycle active-low timer clear
//   o_state                      : IDLE=00 RUN=01 STOP=10 LAP=11
//   o_disp                       : BCD {min_t,min_u,sec_t,sec_u,cs_t,cs_u}
//   o_wrap, o_ovf                : rollover pulse / sticky overflow
//
// Optional build macro STOPWATCH_OVF_HOLD_EN: saturate and stop at the limit instead of wrapping.
module stopwatch_ctrl #(
    parameter int MIN_LIMIT     = 59,
    parameter bit BASETICK_SYNC = 1'b1
) (
    input  logic        i_sclk,
    input  logic        i_reset,
    input  logic        i_start_stop,
    input  logic        i_lap,
    input  logic        i_clear,
    input  logic        i_basetick,
    output logic        o_timerenb,
    output logic        o_timer_clr_n,
    output logic [1:0]  o_state,
    output logic [23:0] o_disp,
    output logic        o_wrap,
    output logic        o_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10,
        ST_LAP  = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_t;

    localparam logic [3:0] MIN_T   = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_U   = 4'(MIN_LIMIT % 10);
    localparam bcd_t       MAX_VAL = {MIN_T, MIN_U, 4'd5, 4'd9, 4'd9, 4'd9};

    state_t state_q, st_t, st_n;
    bcd_t   live_q, lap_q, live_n, lap_n, inc;
    logic   bt, bt_d, tick;
    logic   wrap_n, clr_pulse;
    logic   do_clr, do_ss, do_lap;

`ifdef STOPWATCH_OVF_HOLD_EN
    logic   ovf_q, ovf_n;
    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

    // Optional 2-flop synchronizer on the timer output.
    generate
        if (BASETICK_SYNC) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge i_sclk or posedge i_reset) begin
                if (i_reset) sync_q <= 2'b00;
                else         sync_q <= {sync_q[0], i_basetick};
            end
            assign bt = sync_q[1];
        end else begin : g_nosync
            assign bt = i_basetick;
        end
    endgenerate

    assign tick    = bt & ~bt_d;
    assign o_state = state_q;

    // Strict priority: a higher-priority pulse masks the others even when
    // it is itself ignored in the current state.
    assign do_clr = i_clear;
    assign do_ss  = i_start_stop & ~i_clear;
    assign do_lap = i_lap & ~i_clear & ~i_start_stop;

    always_comb begin
        // BCD ripple increment of the live counter.
        inc = live_q;
        if (live_q.cs_u != 4'd9) inc.cs_u = live_q.cs_u + 4'd1;
        else begin
            inc.cs_u = 4'd0;
            if (live_q.cs_t != 4'd9) inc.cs_t = live_q.cs_t + 4'd1;
            else begin
                inc.cs_t = 4'd0;
                if (live_q.sec_u != 4'd9) inc.sec_u = live_q.sec_u + 4'd1;
                else begin
                    inc.sec_u = 4'd0;
                    if (live_q.sec_t != 4'd5) inc.sec_t = live_q.sec_t + 4'd1;
                    else begin
                        inc.sec_t = 4'd0;
                        if (live_q.min_u != 4'd9) inc.min_u = live_q.min_u + 4'd1;
                        else begin
                            inc.min_u = 4'd0;
                            inc.min_t = live_q.min_t + 4'd1;
                        end
                    end
                end
            end
        end

        st_t      = state_q;
        live_n    = live_q;
        lap_n     = lap_q;
        wrap_n    = 1'b0;
        clr_pulse = 1'b0;
`ifdef STOPWATCH_OVF_HOLD_EN
        ovf_n     = ovf_q;
`endif

        // The tick is applied first; the command then acts on the result.
        if (tick && (state_q == ST_RUN || state_q == ST_LAP)) begin
            if (live_q == MAX_VAL) begin
`ifdef STOPWATCH_OVF_HOLD_EN
                ovf_n = 1'b1;
                st_t  = ST_STOP;
`else
                live_n = '0;
                wrap_n = 1'b1;
`endif
            end else begin
                live_n = inc;
            end
        end

        st_n = st_t;
        unique case (st_t)
            ST_IDLE: begin
                if (do_ss) begin
                    st_n      = ST_RUN;
                    clr_pulse = 1'b1;   // restart timer so the first tick is a full period
                end
            end
            ST_RUN: begin
                if (do_ss) st_n = ST_STOP;
                else if (do_lap) begin
                    st_n  = ST_LAP;
                    lap_n = live_n;     // capture includes a same-cycle tick
                end
            end
            ST_LAP: begin
                if (do_ss)       st_n = ST_STOP;
                else if (do_lap) st_n = ST_RUN;
            end
            ST_STOP: begin
                if (do_clr) begin
                    st_n      = ST_IDLE;
                    live_n    = '0;
                    lap_n     = '0;
                    clr_pulse = 1'b1;
`ifdef STOPWATCH_OVF_HOLD_EN
                    ovf_n     = 1'b0;
                end else if (do_ss && !ovf_n) begin
`else
                end else if (do_ss) begin
`endif
                    st_n = ST_RUN;      // resume without timer clear keeps the tick phase
                end
            end
            default: st_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            live_q        <= '0;
            lap_q         <= '0;
            bt_d          <= 1'b0;
            o_timerenb    <= 1'b0;
            o_timer_clr_n <= 1'b1;
            o_wrap        <= 1'b0;
            o_disp        <= '0;
`ifdef STOPWATCH_OVF_HOLD_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            state_q       <= st_n;
            live_q        <= live_n;
            lap_q         <= lap_n;
            bt_d          <= bt;
            o_timerenb    <= (st_n == ST_RUN) || (st_n == ST_LAP);
            o_timer_clr_n <= ~clr_pulse;
            o_wrap        <= wrap_n;
            o_disp        <= (state_q == ST_LAP) ? lap_q : live_q;
`ifdef STOPWATCH_OVF_HOLD_EN
            ovf_q         <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: vector table, directed corner sequences and a
// random run against a centisecond-count reference model.
module tb_stopwatch_ctrl;

    localparam int MIN_LIMIT = 1;
    localparam int MAXC      = (MIN_LIMIT + 1) * 6000 - 1;

    logic        i_sclk = 1'b0;
    logic        i_reset;
    logic        i_start_stop, i_lap, i_clear, i_basetick;
    logic        o_timerenb, o_timer_clr_n, o_wrap, o_ovf;
    logic [1:0]  o_state;
    logic [23:0] o_disp;

    stopwatch_ctrl #(.MIN_LIMIT(MIN_LIMIT), .BASETICK_SYNC(1'b0)) dut (
        .i_sclk        (i_sclk),
        .i_reset       (i_reset),
        .i_start_stop  (i_start_stop),
        .i_lap         (i_lap),
        .i_clear       (i_clear),
        .i_basetick    (i_basetick),
        .o_timerenb    (o_timerenb),
        .o_timer_clr_n (o_timer_clr_n),
        .o_state       (o_state),
        .o_disp        (o_disp),
        .o_wrap        (o_wrap),
        .o_ovf         (o_ovf)
    );

    always #5 i_sclk = ~i_sclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counter kept as total centiseconds.
    int          m_st, m_cnt, m_lap;
    bit          m_prev_bt, m_enb, m_clr_n, m_wrap, m_ovf;
    logic [23:0] m_disp;

    function automatic logic [23:0] to_bcd(input int c);
        int m, s, cs;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cs = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_lap = 0; m_prev_bt = 0;
        m_enb = 0; m_clr_n = 1; m_wrap = 0; m_ovf = 0; m_disp = '0;
    endtask

    task automatic m_step(input bit ss, input bit lap, input bit clr, input bit bt);
        int  st;
        bit  tick, wrap, cp;
        m_disp    = to_bcd(m_st == 3 ? m_lap : m_cnt);
        tick      = bt && !m_prev_bt;
        m_prev_bt = bt;
        st = m_st; wrap = 0; cp = 0;
        if (tick && (st == 1 || st == 3)) begin
            if (m_cnt == MAXC) begin
`ifdef STOPWATCH_OVF_HOLD_EN
                m_ovf = 1; st = 2;
`else
                m_cnt = 0; wrap = 1;
`endif
            end else m_cnt = m_cnt + 1;
        end
        if (clr) begin
            if (st == 2) begin st = 0; m_cnt = 0; m_lap = 0; m_ovf = 0; cp = 1; end
        end else if (ss) begin
            if (st == 0) begin st = 1; cp = 1; end
            else if (st == 1 || st == 3) st = 2;
            else if (!m_ovf) st = 1;
        end else if (lap) begin
            if (st == 1) begin st = 3; m_lap = m_cnt; end
            else if (st == 3) st = 1;
        end
        m_st = st; m_enb = (st == 1 || st == 3); m_clr_n = !cp; m_wrap = wrap;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, model on posedge, compare 1 ns later.
    task automatic cyc(input bit ss, input bit lap, input bit clr, input bit bt);
        i_start_stop = ss; i_lap = lap; i_clear = clr; i_basetick = bt;
        @(posedge i_sclk);
        m_step(ss, lap, clr, bt);
        #1;
        chk("cycle", {2'b0, o_state, o_disp, o_timerenb, o_timer_clr_n, o_wrap, o_ovf},
            {2'b0, 2'(m_st), m_disp, m_enb, m_clr_n, m_wrap, m_ovf});
        @(negedge i_sclk);
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(0, 0, 0, 1);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic do_reset();
        i_start_stop = 0; i_lap = 0; i_clear = 0; i_basetick = 0;
        i_reset = 1;
        #1;
        m_reset();
        chk("async_reset", {3'b0, o_state, o_disp, o_timerenb, o_timer_clr_n, o_wrap, o_ovf},
            {3'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge i_sclk);
        i_reset = 0;
    endtask

    typedef struct {
        bit          ss, lap, clr, bt;
        bit [1:0]    st;
        logic [23:0] disp;
        bit          enb, clr_n;
    } vec_t;
    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1,0,0,0, 2'd1, 24'h000000, 1, 0};
        tbl[1]  = '{0,0,0,1, 2'd1, 24'h000000, 1, 1};
        tbl[2]  = '{0,0,0,0, 2'd1, 24'h000001, 1, 1};
        tbl[3]  = '{0,1,0,1, 2'd3, 24'h000001, 1, 1};
        tbl[4]  = '{0,0,0,0, 2'd3, 24'h000002, 1, 1};
        tbl[5]  = '{0,0,0,1, 2'd3, 24'h000002, 1, 1};
        tbl[6]  = '{0,1,0,0, 2'd1, 24'h000002, 1, 1};
        tbl[7]  = '{0,0,0,0, 2'd1, 24'h000003, 1, 1};
        tbl[8]  = '{1,0,0,1, 2'd2, 24'h000003, 0, 1};
        tbl[9]  = '{0,0,0,0, 2'd2, 24'h000004, 0, 1};
        tbl[10] = '{0,0,0,1, 2'd2, 24'h000004, 0, 1};
        tbl[11] = '{1,0,0,1, 2'd1, 24'h000004, 1, 1};
        tbl[12] = '{0,0,1,0, 2'd1, 24'h000004, 1, 1};
        tbl[13] = '{1,0,0,1, 2'd2, 24'h000004, 0, 1};
        tbl[14] = '{1,1,1,0, 2'd0, 24'h000005, 0, 0};
        tbl[15] = '{0,0,0,0, 2'd0, 24'h000000, 0, 1};
        tbl[16] = '{0,1,0,0, 2'd0, 24'h000000, 0, 1};
        tbl[17] = '{0,0,1,0, 2'd0, 24'h000000, 0, 1};

        i_start_stop = 0; i_lap = 0; i_clear = 0; i_basetick = 0; i_reset = 1;
        m_reset();
        repeat (2) @(negedge i_sclk);
        i_reset = 0;
        chk("reset_state", {3'b0, o_state, o_disp, o_timerenb, o_timer_clr_n, o_wrap, o_ovf},
            {3'b0, 2'b00, 24'h0, 1'b0, 1'b1, 1'b0, 1'b0});

        // Vector table: hand-derived expectations.
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].ss, tbl[i].lap, tbl[i].clr, tbl[i].bt);
            chk($sformatf("vec%0d", i), {4'b0, o_state, o_disp, o_timerenb, o_timer_clr_n},
                {4'b0, tbl[i].st, tbl[i].disp, tbl[i].enb, tbl[i].clr_n});
        end

        // Start and 150 ticks.
        cyc(1, 0, 0, 0);
        chk("start_clr_low", 32'(o_timer_clr_n), 32'd0);
        cyc(0, 0, 0, 0);
        chk("start_clr_released", 32'(o_timer_clr_n), 32'd1);
        tick_n(150);
        chk("disp_150", 32'(o_disp), 32'h000150);
        chk("run_enb", 32'(o_timerenb), 32'd1);

        // Lap freeze and release.
        tick_n(1084);
        cyc(0, 1, 0, 0);
        tick_n(100);
        chk("lap_frozen", {6'b0, o_state, o_disp}, {6'b0, 2'b11, 24'h001234});
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("lap_release", 32'(o_disp), 32'h001334);

        // Pause ignores ticks, resume without timer clear, then clear.
        cyc(1, 0, 0, 0);
        chk("stop_enb", 32'(o_timerenb), 32'd0);
        tick_n(20);
        cyc(1, 0, 0, 0);
        chk("resume_no_clr", 32'(o_timer_clr_n), 32'd1);
        tick_n(5);
        chk("resume_count", 32'(o_disp), 32'h001339);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("clear_state_clr", {29'b0, o_state, o_timer_clr_n}, {29'b0, 2'b00, 1'b0});
        cyc(0, 0, 0, 0);
        chk("clear_disp", 32'(o_disp), 32'h0);

        // Tick coinciding with stop.
        cyc(1, 0, 0, 0);
        tick_n(9);
        cyc(1, 0, 0, 1);
        chk("tick_stop_state", 32'(o_state), 32'd2);
        cyc(0, 0, 0, 0);
        chk("tick_stop_disp", 32'(o_disp), 32'h000010);
        cyc(1, 1, 1, 0);
        chk("prio_clear", 32'(o_state), 32'd0);

        // Async reset mid-run at 00:03.47.
        cyc(1, 0, 0, 0);
        tick_n(347);
        chk("pre_reset_disp", 32'(o_disp), 32'h000347);
        do_reset();

        // Random commands and base tick against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
        end
        do_reset();

        // Minute carry and rollover at MIN_LIMIT:59.99.
        cyc(1, 0, 0, 0);
        tick_n(5999);
        chk("disp_005999", 32'(o_disp), 32'h005999);
        tick_n(1);
        chk("minute_carry", 32'(o_disp), 32'h010000);
        tick_n(5999);
        chk("disp_limit", 32'(o_disp), 32'h015999);
        cyc(0, 0, 0, 1);
`ifdef STOPWATCH_OVF_HOLD_EN
        chk("ovf_set", {29'b0, o_state, o_ovf}, {29'b0, 2'b10, 1'b1});
        chk("ovf_no_wrap", 32'(o_wrap), 32'd0);
        cyc(0, 0, 0, 0);
        chk("ovf_hold", 32'(o_disp), 32'h015999);
        cyc(1, 0, 0, 0);
        chk("ovf_ss_ignored", 32'(o_state), 32'd2);
        cyc(0, 0, 1, 0);
        chk("ovf_clear", {29'b0, o_state, o_ovf}, {29'b0, 2'b00, 1'b0});
`else
        chk("wrap_pulse", 32'(o_wrap), 32'd1);
        cyc(0, 0, 0, 0);
        chk("wrap_done", {5'b0, o_wrap, o_state, o_disp}, {5'b0, 1'b0, 2'b01, 24'h0});
        tick_n(1);
        chk("wrap_continue", 32'(o_disp), 32'h000001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
